// File: rtl/uart_usart0_if.sv
// Peripheral-port bus bundle between the data-bus decoder and uart_usart0.
// The master drives the request; the slave returns a one-cycle ready with read data.
interface uart_usart0_if;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/uart_usart0.sv
// Memory-mapped ATmega328P-style USART: UDR/UCSRA/UCSRB/UBRR, 16x oversampled 8N1 TX/RX.
// Define UART_PARITY_EN to insert a parity bit (UPM0 selects odd/even) in both directions.
module uart_usart0 #(
  parameter logic [11:0] BAUD_DIV_RESET = 12'd103,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic         clk,
  input  logic         rst,
  uart_usart0_if.slave bus,
  input  logic         uart_rxd,
  output logic         uart_txd
);

`ifdef UART_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic        ready_q, rxen, txen, upm0, pe;
  logic [11:0] ubrr, baud_cnt, ubrr_new;
  logic        tick16;

  logic        acc, wr, rd, wr_udr, wr_ucsra, wr_ucsrb, wr_ubrr, rd_udr;
  logic [1:0]  sel;
  logic [31:0] rd_mux;
  logic        unused_bits;

  // ---------------- bus decode ----------------
  assign acc      = bus.mem_valid && ready_q;
  assign wr       = acc && (bus.mem_wstrb != 4'b0000);
  assign rd       = acc && (bus.mem_wstrb == 4'b0000);
  assign sel      = bus.mem_addr[3:2];
  assign wr_udr   = wr && (sel == 2'd0) && bus.mem_wstrb[0];
  assign wr_ucsra = wr && (sel == 2'd1) && bus.mem_wstrb[0];
  assign wr_ucsrb = wr && (sel == 2'd2) && bus.mem_wstrb[0];
  assign wr_ubrr  = wr && (sel == 2'd3) && (bus.mem_wstrb[1:0] != 2'b00);
  assign rd_udr   = rd && (sel == 2'd0);
  assign ubrr_new = {bus.mem_wstrb[1] ? bus.mem_wdata[11:8] : ubrr[11:8],
                     bus.mem_wstrb[0] ? bus.mem_wdata[7:0]  : ubrr[7:0]};
  assign unused_bits = ^{bus.mem_addr[31:4], bus.mem_addr[1:0],
                         bus.mem_wdata[31:12], bus.mem_wstrb[3:2]};

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q  <= 1'b0;
      rxen     <= 1'b0;
      txen     <= 1'b0;
      ubrr     <= BAUD_DIV_RESET;
      baud_cnt <= '0;
    end else begin
      ready_q <= bus.mem_valid && !ready_q;
      if (wr_ucsrb) begin
        rxen <= bus.mem_wdata[0];
        txen <= bus.mem_wdata[1];
      end
      if (wr_ubrr) begin
        ubrr     <= ubrr_new;
        baud_cnt <= ubrr_new;
      end else if (baud_cnt == '0) begin
        baud_cnt <= ubrr;
      end else begin
        baud_cnt <= baud_cnt - 12'd1;
      end
    end
  end

  assign tick16 = (baud_cnt == '0);

`ifdef UART_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst)           upm0 <= 1'b0;
    else if (wr_ucsrb) upm0 <= bus.mem_wdata[2];
  end
`else
  assign upm0 = 1'b0;
  assign pe   = 1'b0;
`endif

  // ---------------- transmitter ----------------
  state_t      tx_state, tx_next;
  logic [7:0]  tx_buf, tx_shift;
  logic [3:0]  tx_tick;
  logic [2:0]  tx_bit;
  logic        udre, txc, tx_par, tx_load, tx_done, tx_end;

  assign tx_end = tick16 && (tx_tick == 4'd15);

  always_comb begin
    tx_next = tx_state;
    tx_load = 1'b0;
    tx_done = 1'b0;
    case (tx_state)
      S_IDLE:   if (tick16 && txen && !udre) begin tx_next = S_START; tx_load = 1'b1; end
      S_START:  if (tx_end) tx_next = S_DATA;
      S_DATA:   if (tx_end && tx_bit == 3'd7) tx_next = PAR_EN ? S_PARITY : S_STOP;
      S_PARITY: if (tx_end) tx_next = S_STOP;
      S_STOP: begin
        if (tx_end) begin
          tx_done = 1'b1;
          // a waiting byte starts immediately so frames run back to back
          if (txen && !udre) begin tx_next = S_START; tx_load = 1'b1; end
          else                     tx_next = S_IDLE;
        end
      end
      default:  tx_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= S_IDLE;
      tx_buf   <= '0;
      tx_shift <= '0;
      tx_tick  <= '0;
      tx_bit   <= '0;
      tx_par   <= 1'b0;
      udre     <= 1'b1;
      txc      <= 1'b0;
    end else begin
      tx_state <= tx_next;
      if (wr_udr && udre) begin
        tx_buf <= bus.mem_wdata[7:0];
        udre   <= 1'b0;
      end
      if (wr_ucsra && bus.mem_wdata[1]) txc <= 1'b0;
      if (tx_load) begin
        tx_shift <= tx_buf;
        tx_par   <= (^tx_buf) ^ upm0;
        udre     <= 1'b1;
        tx_tick  <= '0;
        tx_bit   <= '0;
      end else if (tx_state != S_IDLE && tick16) begin
        tx_tick <= tx_tick + 4'd1;
        if (tx_state == S_DATA && tx_tick == 4'd15) begin
          tx_shift <= {1'b0, tx_shift[7:1]};
          tx_bit   <= tx_bit + 3'd1;
        end
      end
      if (tx_done) txc <= 1'b1;
    end
  end

  always_comb begin
    case (tx_state)
      S_START:  uart_txd = 1'b0;
      S_DATA:   uart_txd = tx_shift[0];
      S_PARITY: uart_txd = tx_par;
      default:  uart_txd = 1'b1;
    endcase
  end

  // ---------------- receiver ----------------
  state_t                 rx_state, rx_next;
  logic [SYNC_STAGES-1:0] rx_sync;
  logic                   rx_in, rx_prev, rx_sample, rx_end, rx_done;
  logic [3:0]             rx_tick;
  logic [2:0]             rx_bit;
  logic [7:0]             rx_shift, rx_buf;
  logic                   rxc, fe, dor;

  assign rx_in     = rx_sync[SYNC_STAGES-1];
  assign rx_sample = tick16 && (rx_tick == 4'd7);
  assign rx_end    = tick16 && (rx_tick == 4'd15);

  always_comb begin
    rx_next = rx_state;
    rx_done = 1'b0;
    if (!rxen) begin
      rx_next = S_IDLE;
    end else begin
      case (rx_state)
        S_IDLE:   if (rx_prev && !rx_in) rx_next = S_START;
        S_START:  if (rx_sample && rx_in) rx_next = S_IDLE;
                  else if (rx_end)        rx_next = S_DATA;
        S_DATA:   if (rx_end && rx_bit == 3'd7) rx_next = PAR_EN ? S_PARITY : S_STOP;
        S_PARITY: if (rx_end) rx_next = S_STOP;
        S_STOP:   if (rx_sample) begin rx_done = 1'b1; rx_next = S_IDLE; end
        default:  rx_next = S_IDLE;
      endcase
    end
  end

`ifdef UART_PARITY_EN
  logic rx_perr;
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_perr <= 1'b0;
      pe      <= 1'b0;
    end else begin
      if (rx_state == S_PARITY && rx_sample) rx_perr <= ((^rx_shift) ^ upm0) != rx_in;
      if (rx_done && !(rxc && !rd_udr))     pe      <= rx_perr;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sync  <= '1;
      rx_prev  <= 1'b1;
      rx_state <= S_IDLE;
      rx_tick  <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_buf   <= '0;
      rxc      <= 1'b0;
      fe       <= 1'b0;
      dor      <= 1'b0;
    end else begin
      rx_sync  <= {rx_sync[SYNC_STAGES-2:0], uart_rxd};
      rx_prev  <= rx_in;
      rx_state <= rx_next;
      if (rx_state == S_IDLE) begin
        rx_tick <= '0;
        rx_bit  <= '0;
      end else if (tick16) begin
        rx_tick <= rx_tick + 4'd1;
      end
      if (rx_state == S_DATA && rx_sample) rx_shift <= {rx_in, rx_shift[7:1]};
      if (rx_state == S_DATA && rx_end)    rx_bit   <= rx_bit + 3'd1;
      if (rd_udr) rxc <= 1'b0;
      // a same-cycle UDR read frees the buffer, so the new byte lands without overrun
      if (rx_done) begin
        if (rxc && !rd_udr) begin
          dor <= 1'b1;
        end else begin
          rx_buf <= rx_shift;
          rxc    <= 1'b1;
          dor    <= 1'b0;
          fe     <= !rx_in;
        end
      end
    end
  end

  // ---------------- read mux ----------------
  always_comb begin
    rd_mux = '0;
    case (sel)
      2'd0: rd_mux = {24'h0, rx_buf};
      2'd1: rd_mux = {26'h0, pe, dor, fe, udre, txc, rxc};
      2'd2: rd_mux = {29'h0, upm0, txen, rxen};
      2'd3: rd_mux = {20'h0, ubrr};
      default: rd_mux = '0;
    endcase
  end

  assign bus.mem_ready = ready_q;
  assign bus.mem_rdata = ready_q ? rd_mux : '0;

endmodule
